mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: cycles to wait for mem_rvalid before an error response; legal range 2..255.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port if_req, input, 1: fetch request.
REQ-006 SHALL have port if_addr, input, AW: fetch address.
REQ-007 SHALL have port if_gnt, output, 1: fetch request accepted.
REQ-008 SHALL have port if_rvalid, output, 1: fetch response valid.
REQ-009 SHALL have port if_err, output, 1: fetch response is a timeout.
REQ-010 SHALL have port if_rdata, output, 32: fetch data.
REQ-011 SHALL have port ls_req, input, 1: load/store request.
REQ-012 SHALL have port ls_we, input, 1: store when 1.
REQ-013 SHALL have port ls_addr, input, AW: load/store address.
REQ-014 SHALL have port ls_wdata, input, 32: store data.
REQ-015 SHALL have port ls_mode, input, 3: access mode (funct3 encoding).
REQ-016 SHALL have port ls_gnt, output, 1: load/store request accepted.
REQ-017 SHALL have port ls_rvalid, output, 1: load/store response valid.
REQ-018 SHALL have port ls_err, output, 1: load/store response is a timeout.
REQ-019 SHALL have port ls_rdata, output, 32: load data.
REQ-020 SHALL have ports mem_req, mem_we, mem_addr, mem_wdata and mem_mode, all outputs: the selected request forwarded to memory.
REQ-021 SHALL have port mem_gnt, input, 1: memory accepts request.
REQ-022 SHALL have port mem_rvalid, input, 1: memory response or store ack.
REQ-023 SHALL have port mem_rdata, input, 32: memory data.

Function
REQ-024 SHALL implement FSM IDLE, WAIT_IF, WAIT_LS; one outstanding transaction max.
REQ-025 In IDLE: mem_req = if_req|ls_req; mem_* fields driven combinationally from the winner; when neither requests, mem_we=0 and mem_req=0.
REQ-026 Default arbitration: ls wins when both request.
REQ-027 Winner's gnt SHALL assert combinationally only when state=IDLE and mem_req=1 and mem_gnt=1; the loser's gnt stays 0.
REQ-028 On grant SHALL go to WAIT_IF or WAIT_LS next cycle; mem_req=0 in any WAIT state.
REQ-029 In WAIT_x with mem_rvalid=1: x_rvalid=1 and x_rdata=mem_rdata for one cycle (combinational), x_err=0, next state IDLE.
REQ-030 Stores SHALL complete via mem_rvalid (ack); ls_rdata is don't-care on a store ack.
REQ-031 Timeout counter (8 bit) SHALL clear on grant and increment each WAIT cycle without mem_rvalid.
REQ-032 When the counter reaches TIMEOUT-1 with no mem_rvalid: x_rvalid=1, x_err=1, x_rdata=0; next state IDLE.
REQ-033 mem_rvalid in IDLE SHALL be ignored (no rvalid to either side).
REQ-034 There SHALL be at least one IDLE cycle between a response and the next grant (no same-cycle back-to-back).
REQ-035 Requesters hold req/addr stable until gnt; a req dropped before gnt is not an error.

Reset
REQ-036 rst low SHALL force state IDLE, counter 0 and RR pointer to ls, asynchronously.
REQ-037 During reset all gnt, rvalid and err outputs SHALL be 0, mem_req=0 and rdata=0.
REQ-038 Reset mid-WAIT SHALL abandon the transaction; a late mem_rvalid after reset is ignored per REQ-033.

Configuration
REQ-039 With ARB_RR_EN defined: on a tie, the requester not granted last wins; the pointer updates on each grant.
REQ-040 Without ARB_RR_EN: fixed ls priority and no pointer flop.

Structure
REQ-041 Package mem_arb_pkg SHALL hold the state enum (IDLE/WAIT_IF/WAIT_LS) and an owner enum (OWN_IF/OWN_LS).
REQ-042 Sub-module arb_pick SHALL be a 2-way picker (fixed or RR) returning a one-hot winner; everything else lives in mem_arbiter.

Verification
REQ-043 if_req=1, addr 0x100; mem_gnt=1; mem_rvalid with 0xDEADBEEF two cycles later -> if_gnt cycle 0, if_rvalid with 0xDEADBEEF, if_err=0.
REQ-044 Both req, no ARB_RR_EN, three transactions -> ls granted each time; if granted only after ls_req drops.
REQ-045 Both req held, ARB_RR_EN -> grant order ls, if, ls, if.
REQ-046 TIMEOUT=4, no mem_rvalid -> ls_rvalid=1, ls_err=1, ls_rdata=0 on the 4th WAIT cycle; next cycle IDLE, grants resume.
REQ-047 ls store, wdata 0x12345678, mode 3'b010 -> mem_we=1 and mem fields match; ack ends in ls_rvalid.
REQ-048 rst low during WAIT_LS, then mem_rvalid after release -> no rvalid on either side; state IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the fetch / load-store memory
//            arbiter: FSM state encoding, requester ownership encoding and
//            the fixed access mode used for instruction fetches.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  // Arbiter FSM: one outstanding transaction, owner encoded in the state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_LS = 2'd2
  } arb_state_t;

  // Requester identity, also used as the round-robin priority pointer.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Fetches are always full-word accesses (funct3 LW encoding).
  localparam logic [2:0] c_fetch_mode = 3'b010;

  // Width of the response timeout counter.
  localparam int c_cnt_w = 8;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arbiter_pick.sv
//------------------------------------------------------------------------------
// Module   : arb_pick
// Purpose  : Two-way requester picker returning a one-hot winner
//            (win[1] = load/store, win[0] = fetch, all-zero when idle).
//            Default build: fixed load/store priority, no state.
//            With ARB_RR_EN defined: round-robin on ties, the requester not
//            granted last wins; the pointer moves on every grant.
// Ports    : clk, rst (async, active-low), advance  - RR build only
//            req_if, req_ls                         - requests
//            win[1:0]                               - one-hot winner
// Config   : ARB_RR_EN
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_pick
  import mem_arb_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
`endif
  input  logic       req_if,
  input  logic       req_ls,
  output logic [1:0] win
);

`ifdef ARB_RR_EN
  owner_t r_prio;
  logic   w_ls_wins;

  // The pointer names the side that wins the next tie.
  always_comb begin
    w_ls_wins = req_ls & (~req_if | (r_prio == OWN_LS));
    win       = {w_ls_wins, req_if & ~w_ls_wins};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio <= OWN_LS;
    end else if (advance) begin
      // Hand priority to whoever did not just win.
      r_prio <= win[1] ? OWN_IF : OWN_LS;
    end
  end
`else
  always_comb begin
    win = {req_ls, req_if & ~req_ls};
  end
`endif

endmodule : arb_pick

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_arbiter
// Purpose  : Arbitrates an instruction-fetch port and a load/store port onto
//            a single memory port with one outstanding transaction. A
//            response (mem_rvalid) or a timeout after TIMEOUT wait cycles
//            returns to the owner, then the FSM spends at least one cycle in
//            IDLE before the next grant.
// Params   : TIMEOUT (2..255) wait cycles before an error response
//            AW      address width
// Ports    : clk, rst (async, active-low)
//            if_req/if_addr -> if_gnt/if_rvalid/if_err/if_rdata
//            ls_req/ls_we/ls_addr/ls_wdata/ls_mode
//                           -> ls_gnt/ls_rvalid/ls_err/ls_rdata
//            mem_req/mem_we/mem_addr/mem_wdata/mem_mode -> memory
//            mem_gnt/mem_rvalid/mem_rdata <- memory
// Config   : ARB_RR_EN - round-robin tie break instead of fixed ls priority
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic          if_err,
  output logic [31:0]   if_rdata,
  // load/store port
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  input  logic [2:0]    ls_mode,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic          ls_err,
  output logic [31:0]   ls_rdata,
  // memory port
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [2:0]    mem_mode,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  // Last wait-cycle count before the error response fires.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         w_win;
  logic               w_grant;
  logic               w_timeout;

  arb_pick u_pick (
`ifdef ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
    .advance (w_grant),
`endif
    .req_if  (if_req),
    .req_ls  (ls_req),
    .win     (w_win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Timeout counter: restarts on grant, counts WAIT cycles with no response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_grant) begin
      r_cnt <= '0;
    end else if ((r_state != IDLE) && !mem_rvalid) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_timeout = (r_cnt == c_cnt_last);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mode  = '0;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_err    = 1'b0;
    if_rdata  = '0;
    ls_gnt    = 1'b0;
    ls_rvalid = 1'b0;
    ls_err    = 1'b0;
    ls_rdata  = '0;

    case (r_state)
      IDLE: begin
        // Request path is combinational; gate with rst so nothing leaks out
        // while reset is held. mem_rvalid is deliberately ignored here.
        if (rst) begin
          mem_req = if_req | ls_req;
          if (w_win[1]) begin
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_mode  = ls_mode;
          end else if (w_win[0]) begin
            mem_addr  = if_addr;
            mem_mode  = c_fetch_mode;
          end
          w_grant = mem_req & mem_gnt;
          ls_gnt  = w_grant & w_win[1];
          if_gnt  = w_grant & w_win[0];
          if (ls_gnt) begin
            w_next = WAIT_LS;
          end else if (if_gnt) begin
            w_next = WAIT_IF;
          end
        end
      end

      WAIT_IF: begin
        if (mem_rvalid) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
          w_next    = IDLE;
        end else if (w_timeout) begin
          if_rvalid = 1'b1;
          if_err    = 1'b1;
          w_next    = IDLE;
        end
      end

      WAIT_LS: begin
        // A store ack also arrives here; ls_rdata then carries no meaning.
        if (mem_rvalid) begin
          ls_rvalid = 1'b1;
          ls_rdata  = mem_rdata;
          w_next    = IDLE;
        end else if (w_timeout) begin
          ls_rvalid = 1'b1;
          ls_err    = 1'b1;
          w_next    = IDLE;
        end
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter (TIMEOUT = 4). Vector table
//            for arbitration / forwarding, scoreboard queue for responses,
//            hand-written sequences for reset abandonment and held-request
//            grant order. Follows ARB_RR_EN like the design.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic [2:0]  ls_mode;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_mode;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  mem_arbiter #(.TIMEOUT(TO), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_err(if_err), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_mode(ls_mode), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_err(ls_err), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mode(mem_mode), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        is_ls;
    logic        err;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        if_req, ls_req, ls_we, mem_gnt;
    logic [31:0] if_addr, ls_addr, wdata;
    logic [2:0]  mode;
    int          resp_at;      // WAIT cycle carrying mem_rvalid, 0 = never
    logic [31:0] rdata;
    logic        win_ls_fix;   // expected winner, fixed priority
    logic        win_ls_rr;    // expected winner, round robin
    logic        exp_req;
    logic        exp_we;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && (if_rvalid === 1'b1 || ls_rvalid === 1'b1)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got if_rvalid=%b ls_rvalid=%b expected none at %0t",
                 if_rvalid, ls_rvalid, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_side_ls", 32'(ls_rvalid), 32'(e.is_ls));
        chk("resp_side_if", 32'(if_rvalid), 32'(!e.is_ls));
        chk("resp_err", 32'(e.is_ls ? ls_err : if_err), 32'(e.err));
        if (e.chk_data) chk("resp_rdata", e.is_ls ? ls_rdata : if_rdata, e.data);
      end
    end
  end

  // One held-request transaction: grant checked, response one cycle later.
  task automatic hold_txn(input logic exp_ls, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    chk("hold_ls_gnt", 32'(ls_gnt), 32'(exp_ls));
    chk("hold_if_gnt", 32'(if_gnt), 32'(!exp_ls));
    e.is_ls = exp_ls; e.err = 1'b0; e.chk_data = 1'b1; e.data = d;
    sb.push_back(e);
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    @(negedge clk);
    chk("hold_wait_quiet", 32'({mem_req, if_gnt, ls_gnt}), 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("hold_resp_seen", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  vec_t vec[10];

  initial begin
    logic  w_ls;
    logic  g;
    exp_t  e;

    // {if_req, ls_req, ls_we, mem_gnt, if_addr, ls_addr, wdata, mode,
    //  resp_at, rdata, win_ls_fix, win_ls_rr, exp_req, exp_we}
    vec[0] = '{1, 0, 0, 1, 32'h0000_0100, 32'h0,        32'h0,         3'b000, 2, 32'hDEAD_BEEF, 0, 0, 1, 0};
    vec[1] = '{0, 0, 1, 1, 32'h0000_0200, 32'h0000_0300, 32'h0,        3'b010, 0, 32'h0,         0, 0, 0, 0};
    vec[2] = '{1, 0, 0, 0, 32'h0000_0204, 32'h0,        32'h0,         3'b000, 0, 32'h0,         0, 0, 1, 0};
    vec[3] = '{1, 1, 0, 1, 32'h0000_0208, 32'h0000_0400, 32'h0,        3'b010, 1, 32'hA5A5_0001, 1, 1, 1, 0};
    vec[4] = '{1, 1, 0, 1, 32'h0000_020C, 32'h0000_0404, 32'h0,        3'b001, 3, 32'h0BAD_F00D, 1, 0, 1, 0};
    vec[5] = '{0, 1, 1, 1, 32'h0,        32'h0000_0800, 32'h1234_5678, 3'b010, 2, 32'hFFFF_FFFF, 1, 1, 1, 1};
    vec[6] = '{0, 1, 0, 1, 32'h0,        32'h0000_0804, 32'h0,         3'b100, 0, 32'hCAFE_BABE, 1, 1, 1, 0};
    vec[7] = '{1, 0, 0, 1, 32'h0000_0210, 32'h0,        32'h0,         3'b000, 0, 32'h1357_9BDF, 0, 0, 1, 0};
    vec[8] = '{1, 1, 1, 1, 32'h0000_0214, 32'h0000_0808, 32'h0F0F_0F0F, 3'b010, 4, 32'h2468_ACE0, 1, 1, 1, 1};
    vec[9] = '{0, 1, 0, 0, 32'h0,        32'h0000_080C, 32'h0,         3'b000, 0, 32'h0,         1, 1, 1, 0};

    // Reset with every input busy: all outputs must stay quiet.
    rst = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1;
    if_addr = 32'h40; ls_addr = 32'h80; ls_wdata = 32'h55; ls_mode = 3'b010;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
    chk("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
    chk("rst_err", 32'({if_err, ls_err}), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;

    // Table-driven arbitration and forwarding.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if_req   = vec[i].if_req;  ls_req  = vec[i].ls_req;  ls_we = vec[i].ls_we;
      if_addr  = vec[i].if_addr; ls_addr = vec[i].ls_addr;
      ls_wdata = vec[i].wdata;   ls_mode = vec[i].mode;
      mem_gnt  = vec[i].mem_gnt; mem_rvalid = 1'b0; mem_rdata = vec[i].rdata;
`ifdef ARB_RR_EN
      w_ls = vec[i].win_ls_rr;
`else
      w_ls = vec[i].win_ls_fix;
`endif
      g = vec[i].exp_req & vec[i].mem_gnt;
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vec[i].exp_req));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vec[i].exp_we));
      chk($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(g & !w_ls));
      chk($sformatf("v%0d_ls_gnt", i), 32'(ls_gnt), 32'(g & w_ls));
      if (vec[i].exp_req)
        chk($sformatf("v%0d_mem_addr", i), mem_addr, w_ls ? vec[i].ls_addr : vec[i].if_addr);
      if (vec[i].exp_req && w_ls) begin
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vec[i].wdata);
        chk($sformatf("v%0d_mem_mode", i), 32'(mem_mode), 32'(vec[i].mode));
      end
      if (g) begin
        e.is_ls    = w_ls;
        e.err      = (vec[i].resp_at == 0);
        e.chk_data = e.err || !(w_ls && vec[i].ls_we);
        e.data     = e.err ? 32'h0 : vec[i].rdata;
        sb.push_back(e);
        for (int c = 1; c <= TO; c++) begin
          @(posedge clk); #1;
          mem_gnt    = 1'b1;
          mem_rvalid = (c == vec[i].resp_at);
          @(negedge clk);
          if (c == 1) chk($sformatf("v%0d_wait_quiet", i), 32'({mem_req, if_gnt, ls_gnt}), 32'd0);
          if (c == vec[i].resp_at) break;
        end
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_gnt = 1'b0; if_req = 1'b1; ls_req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_idle_after", i), 32'(mem_req), 32'd1);
        chk($sformatf("v%0d_resp_seen", i), 32'(sb.size()), 32'd0);
        sb.delete();
      end
    end

    // Reset in WAIT_LS abandons the transaction; a late ack is ignored.
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h900; mem_gnt = 1'b1;
    @(negedge clk);
    chk("rstw_ls_gnt", 32'(ls_gnt), 32'd1);
    @(posedge clk); #1;
    ls_req = 1'b0; mem_gnt = 1'b0;
    #3 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rstw_quiet", 32'({mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777; if_req = 1'b1;
    @(negedge clk);
    chk("rstw_no_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
    chk("rstw_idle", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    mem_rvalid = 1'b0; if_req = 1'b0;

    // Fresh reset so the round-robin pointer starts at ls.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; mem_gnt = 1'b1;
`ifdef ARB_RR_EN
    hold_txn(1'b1, 32'h1111_0001);
    hold_txn(1'b0, 32'h1111_0002);
    hold_txn(1'b1, 32'h1111_0003);
    hold_txn(1'b0, 32'h1111_0004);
`else
    hold_txn(1'b1, 32'h2222_0001);
    hold_txn(1'b1, 32'h2222_0002);
    hold_txn(1'b1, 32'h2222_0003);
    ls_req = 1'b0;
    hold_txn(1'b0, 32'h2222_0004);
`endif
    if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0;
    repeat (2) @(posedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_arbiter

`default_nettype wire
